// File: rtl/ssd1306_spi_receiver_if.sv
// Signal bundle for the SSD1306 4-wire SPI link and the decoded byte/framebuffer outputs.
// The master side drives the SPI pins; the slave side is the receiver.
interface ssd1306_spi_receiver_if;
  logic       spi_csn_in;
  logic       spi_dc_in;
  logic       spi_clk_in;
  logic       spi_mosi_in;
  logic       byte_valid_out;
  logic [7:0] byte_out;
  logic       byte_is_data_out;
  logic       fb_we_out;
  logic [9:0] fb_addr_out;
  logic [7:0] fb_data_out;
  logic [2:0] page_out;
  logic [6:0] col_out;
  logic [1:0] mode_out;
  logic       display_on_out;
  logic       cmd_error_out;

  modport master (
    output spi_csn_in, spi_dc_in, spi_clk_in, spi_mosi_in,
    input  byte_valid_out, byte_out, byte_is_data_out, fb_we_out, fb_addr_out, fb_data_out,
    input  page_out, col_out, mode_out, display_on_out, cmd_error_out
  );

  modport slave (
    input  spi_csn_in, spi_dc_in, spi_clk_in, spi_mosi_in,
    output byte_valid_out, byte_out, byte_is_data_out, fb_we_out, fb_addr_out, fb_data_out,
    output page_out, col_out, mode_out, display_on_out, cmd_error_out
  );
endinterface

// File: rtl/ssd1306_spi_receiver.sv
// Display-side SSD1306 SPI receiver: oversamples the link, assembles bytes, decodes
// addressing commands and emits framebuffer writes with page/column addresses.
module ssd1306_spi_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COLUMNS     = 128,
  parameter int unsigned PAGES       = 8
) (
  input logic                   clk_in,
  input logic                   rstn_in,
  ssd1306_spi_receiver_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StArg} state_e;

  // Per stage: {mosi, sclk, dc, csn}; csn resets high so nothing shifts out of reset.
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic csn_s, dc_s, sclk_s, mosi_s;
  logic sclk_prev_q;
  logic sclk_rise;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] rx_byte;
  logic       rx_done;

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [2:0] args_left_q, args_left_d;
  logic [2:0] n_args;
  logic [6:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [2:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic [1:0] mode_q, mode_d;
  logic       display_on_q, display_on_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_q, byte_d;
  logic       byte_is_data_q, byte_is_data_d;
  logic       fb_we_q, fb_we_d;
  logic [9:0] fb_addr_q, fb_addr_d;
  logic [7:0] fb_data_q, fb_data_d;
  logic       cmd_error_q, cmd_error_d;
  logic       col_at_end, page_at_end;

  assign sync_d = {sync_q[SYNC_STAGES-2:0],
                   {bus.spi_mosi_in, bus.spi_clk_in, bus.spi_dc_in, bus.spi_csn_in}};
  assign {mosi_s, sclk_s, dc_s, csn_s} = sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign rx_byte   = {shift_q, mosi_s};

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_done   = 1'b0;
    if (csn_s) begin
      bit_cnt_d = '0;
    end else if (sclk_rise) begin
      shift_d   = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      rx_done   = (bit_cnt_q == 3'd7);
    end
  end

  assign col_at_end  = (col_q == col_end_q);
  assign page_at_end = (page_q == page_end_q);

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    args_left_d    = args_left_q;
    n_args         = 3'd0;
    col_d          = col_q;
    col_start_d    = col_start_q;
    col_end_d      = col_end_q;
    page_d         = page_q;
    page_start_d   = page_start_q;
    page_end_d     = page_end_q;
    mode_d         = mode_q;
    display_on_d   = display_on_q;
    byte_valid_d   = 1'b0;
    byte_d         = byte_q;
    byte_is_data_d = byte_is_data_q;
    fb_we_d        = 1'b0;
    fb_addr_d      = fb_addr_q;
    fb_data_d      = fb_data_q;
    cmd_error_d    = 1'b0;

    if (rx_done) begin
      byte_valid_d   = 1'b1;
      byte_d         = rx_byte;
      byte_is_data_d = dc_s;
      if (dc_s) begin
        fb_we_d   = 1'b1;
        fb_addr_d = 10'(32'(page_q) * COLUMNS + 32'(col_q));
        fb_data_d = rx_byte;
        if (state_q == StArg) begin
          cmd_error_d = 1'b1;
          args_left_d = '0;
          state_d     = StIdle;
        end
        case (mode_q)
          2'd0: begin
            if (col_at_end) begin
              col_d  = col_start_q;
              page_d = page_at_end ? page_start_q : page_q + 3'd1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end
          2'd1: begin
            if (page_at_end) begin
              page_d = page_start_q;
              col_d  = col_at_end ? col_start_q : col_q + 7'd1;
            end else begin
              page_d = page_q + 3'd1;
            end
          end
          default: col_d = col_at_end ? col_start_q : col_q + 7'd1;
        endcase
      end else if (state_q == StArg) begin
        args_left_d = args_left_q - 3'd1;
        if (args_left_q == 3'd1) state_d = StIdle;
        // Two-argument commands: args_left == 2 marks the first argument.
        case (cmd_q)
          8'h20: mode_d = (rx_byte[1:0] == 2'd3) ? 2'd2 : rx_byte[1:0];
          8'h21: begin
            if (args_left_q == 3'd2) begin
              col_start_d = rx_byte[6:0];
            end else begin
              col_end_d = rx_byte[6:0];
              col_d     = col_start_q;
            end
          end
          8'h22: begin
            if (args_left_q == 3'd2) begin
              page_start_d = rx_byte[2:0];
            end else begin
              page_end_d = rx_byte[2:0];
              page_d     = page_start_q;
            end
          end
          default: ;
        endcase
      end else begin
        cmd_d = rx_byte;
        casez (rx_byte)
          8'b0000_????: col_d[3:0] = rx_byte[3:0];
          8'b0001_0???: col_d[6:4] = rx_byte[2:0];
          8'b1011_0???: page_d = rx_byte[2:0];
          8'hAE: display_on_d = 1'b0;
          8'hAF: display_on_d = 1'b1;
          8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: n_args = 3'd1;
          8'h21, 8'h22, 8'hA3: n_args = 3'd2;
          8'h29, 8'h2A: n_args = 3'd5;
          8'h26, 8'h27: n_args = 3'd6;
          default: ;
        endcase
        if (n_args != 3'd0) begin
          state_d     = StArg;
          args_left_d = n_args;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      sync_q         <= {SYNC_STAGES{4'b0001}};
      sclk_prev_q    <= 1'b0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      state_q        <= StIdle;
      cmd_q          <= '0;
      args_left_q    <= '0;
      col_q          <= '0;
      col_start_q    <= '0;
      col_end_q      <= 7'(COLUMNS - 1);
      page_q         <= '0;
      page_start_q   <= '0;
      page_end_q     <= 3'(PAGES - 1);
      mode_q         <= 2'd2;
      display_on_q   <= 1'b0;
      byte_valid_q   <= 1'b0;
      byte_q         <= '0;
      byte_is_data_q <= 1'b0;
      fb_we_q        <= 1'b0;
      fb_addr_q      <= '0;
      fb_data_q      <= '0;
      cmd_error_q    <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      sclk_prev_q    <= sclk_s;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      args_left_q    <= args_left_d;
      col_q          <= col_d;
      col_start_q    <= col_start_d;
      col_end_q      <= col_end_d;
      page_q         <= page_d;
      page_start_q   <= page_start_d;
      page_end_q     <= page_end_d;
      mode_q         <= mode_d;
      display_on_q   <= display_on_d;
      byte_valid_q   <= byte_valid_d;
      byte_q         <= byte_d;
      byte_is_data_q <= byte_is_data_d;
      fb_we_q        <= fb_we_d;
      fb_addr_q      <= fb_addr_d;
      fb_data_q      <= fb_data_d;
      cmd_error_q    <= cmd_error_d;
    end
  end

  assign bus.byte_valid_out   = byte_valid_q;
  assign bus.byte_out         = byte_q;
  assign bus.byte_is_data_out = byte_is_data_q;
  assign bus.fb_we_out        = fb_we_q;
  assign bus.fb_addr_out      = fb_addr_q;
  assign bus.fb_data_out      = fb_data_q;
  assign bus.page_out         = page_q;
  assign bus.col_out          = col_q;
  assign bus.mode_out         = mode_q;
  assign bus.display_on_out   = display_on_q;
  assign bus.cmd_error_out    = cmd_error_q;

endmodule

// File: doc/ssd1306_spi_receiver.md
Name: ssd1306_spi_receiver

Overview:
- Display-side end of the 4-wire SSD1306 SPI link (CSn, D/C, SCLK, MOSI) that the OLED driver transmits on.
- Oversamples the SPI pins on the system clock and assembles bytes.
- Decodes the SSD1306 addressing commands and emits framebuffer write strobes with page/column address.
- Used for on-chip loopback checking of the OLED frequency counter and as a synthesizable display model in benches.

Parameters:
- SYNC_STAGES, 2: synchronizer flops per SPI input (min 2).
- COLUMNS, 128: display width; column pointer is 7 bits.
- PAGES, 8: display pages; page pointer is 3 bits.

Ports:
- clk_in  input  1  system clock; must be ≥4× SCLK frequency.
- rstn_in  input  1  asynchronous active-low reset.
- spi_csn_in  input  1  chip select, active low.
- spi_dc_in  input  1  0 = command byte, 1 = data byte.
- spi_clk_in  input  1  SCLK, mode 0 (idle low, sample on rising edge).
- spi_mosi_in  input  1  serial data, MSB first.
- byte_valid_out  output  1  one-cycle pulse per received byte.
- byte_out  output  8  received byte.
- byte_is_data_out  output  1  D/C value latched with the byte.
- fb_we_out  output  1  one-cycle framebuffer write strobe.
- fb_addr_out  output  10  page*128 + column.
- fb_data_out  output  8  pixel column byte (bit0 = top row of the page).
- page_out  output  3  current page pointer.
- col_out  output  7  current column pointer.
- mode_out  output  2  addressing mode: 0 = horizontal, 1 = vertical, 2 = page.
- display_on_out  output  1  set by 0xAF, cleared by 0xAE.
- cmd_error_out  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset state: all outputs 0 except mode_out = 2. col_start = 0, col_end = 127, page_start = 0, page_end = 7, args_left = 0, bit_cnt = 0.
- Input path: all SPI inputs pass through SYNC_STAGES flops. Rising SCLK is detected on the synchronized signal. Shifting occurs only while synchronized CSn = 0.
- On the 8th rising edge, D/C is latched. byte_valid_out pulses in the following cycle; total latency is SYNC_STAGES+1 clk_in cycles from the SCLK pin edge.
- CSn rising mid-byte discards the partial byte and clears bit_cnt. Parser state (pointers, args_left) is kept.
- Parser states:
  - IDLE, on a command byte:
    - 0x00–0x0F: col[3:0] = b[3:0].
    - 0x10–0x17: col[6:4] = b[2:0].
    - 0xB0–0xB7: page = b[2:0].
    - 0xAE / 0xAF: display off / on.
    - 0x20: ARG, 1 argument; sets mode = arg[1:0], with 3 treated as 2.
    - 0x21: ARG, 2 arguments; col_start = a1[6:0], col_end = a2[6:0], col = col_start.
    - 0x22: ARG, 2 arguments; page_start = a1[2:0], page_end = a2[2:0], page = page_start.
    - Skip-only ARG (no effect), 1 argument: 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB.
    - Skip-only ARG, 2 arguments: 0xA3.
    - Skip-only ARG, 5 arguments: 0x29, 0x2A.
    - Skip-only ARG, 6 arguments: 0x26, 0x27.
    - All other commands are ignored.
  - ARG: each command byte decrements args_left; return to IDLE at 0.
- Data byte:
  - fb_we_out pulses in the same cycle as byte_valid_out, using the current pointers; the pointers update on the next edge.
  - If it arrives in ARG: cmd_error_out pulses, args_left clears, and the write still occurs.
- Pointer advance after each data write:
  - Page mode: col+1; col_end wraps to col_start; page unchanged.
  - Horizontal mode: col+1; at col_end, col = col_start and page+1; at page_end, page wraps to page_start.
  - Vertical mode: page+1; at page_end, page = page_start and col+1; at col_end, col wraps to col_start.
- A command byte never produces fb_we_out.
- Reset mid-byte or mid-argument returns immediately to the reset state.

Test Plan:
- Reset, then command 0xAF → display_on_out = 1, one byte_valid_out pulse with byte_is_data_out = 0, no fb_we_out.
- Commands 0xB3, 0x05, 0x12, then data 0xA5 → fb_we_out with fb_addr_out = 3*128+37 = 421 and fb_data_out = 0xA5; afterwards col_out = 38.
- Commands 0x20 0x00, 0x21 0x7E 0x7F, 0x22 0x06 0x07, then 5 data bytes → addresses 894, 895, 1022, 1023, 894.
- Vertical mode (0x20 0x01), default ranges, 9 data bytes → addresses 0, 128, …, 896, then 1 (column wraps +1 after page 7).
- Command 0x81 followed by data 0x55 → cmd_error_out pulses, write goes to address 0; a following 0xAF is decoded as a command.
- CSn raised after 5 bits, then a full data byte 0xFF → exactly one byte_valid_out with byte_out = 0xFF.
